// File: rtl/pipe_reg_if.sv
// Handshake bundle for pipe_reg: upstream valid/ready/data, downstream
// valid/ready/data, synchronous flush and occupancy count.
interface pipe_reg_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(2*DEPTH+1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_reg.sv
// Elastic register chain: DEPTH two-entry skid-buffer slices with valid/ready
// flow control, synchronous flush and an occupancy count.
module pipe_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic       clock,
  input logic       reset,
  pipe_reg_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(2*DEPTH+1);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } slice_state_e;

  logic [DEPTH-1:0] main_v;
  logic [DEPTH-1:0] skid_v;
  logic [DEPTH-1:0] accept;
  logic [DEPTH-1:0] take;
  logic [WIDTH-1:0] main_d  [DEPTH];
  logic [WIDTH-1:0] up_data [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic             in_xfer;
  logic             out_xfer;

  assign bus.in_ready  = reset & ~skid_v[0] & ~bus.flush;
  assign bus.out_valid = main_v[DEPTH-1] & ~bus.flush;
  assign bus.out_data  = main_d[DEPTH-1];
  assign bus.count     = count_q;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slice
    logic             main_v_q;
    logic             skid_v_q;
    logic [WIDTH-1:0] main_d_q;
    logic [WIDTH-1:0] skid_d_q;

    // A slice-to-slice move is the upstream slice's take; ready is only !skid_v.
    if (i == 0) begin : g_head
      assign accept[i]  = in_xfer;
      assign up_data[i] = bus.in_data;
    end else begin : g_link
      assign accept[i]  = take[i-1];
      assign up_data[i] = main_d[i-1];
    end

    if (i == DEPTH-1) begin : g_tail
      assign take[i] = out_xfer;
    end else begin : g_mid
      assign take[i] = main_v_q & ~skid_v[i+1] & ~bus.flush;
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        // NOTE: non-blocking assignments so every slice sees its neighbours' pre-edge state.
        main_v_q <= 1'b0;
        skid_v_q <= 1'b0;
        // NOTE: data registers are reset as well so out_data shows RESET_VAL out of reset.
        main_d_q <= RESET_VAL;
        skid_d_q <= RESET_VAL;
      end else if (bus.flush) begin
        main_v_q <= 1'b0;
        skid_v_q <= 1'b0;
      end else begin
        case (slice_state_e'({main_v_q, skid_v_q}))
          EMPTY: begin
            if (accept[i]) begin
              main_v_q <= 1'b1;
              main_d_q <= up_data[i];
            end
          end
          BUSY: begin
            if (accept[i] && take[i]) begin
              main_d_q <= up_data[i];
            end else if (accept[i]) begin
              skid_v_q <= 1'b1;
              skid_d_q <= up_data[i];
            end else if (take[i]) begin
              main_v_q <= 1'b0;
            end
          end
          FULL: begin
            if (take[i]) begin
              main_d_q <= skid_d_q;
              skid_v_q <= 1'b0;
            end
          end
          default: begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
          end
        endcase
      end
    end

    assign main_v[i] = main_v_q;
    assign skid_v[i] = skid_v_q;
    assign main_d[i] = main_d_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (bus.flush) begin
      count_q <= '0;
    end else if (in_xfer && !out_xfer) begin
      count_q <= count_q + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      count_q <= count_q - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_reg.sv
// Directed checks of pipe_reg (DEPTH=2, WIDTH=8) plus a random-stall
// scoreboard run on a DEPTH=1, WIDTH=32 instance.
module tb_pipe_reg;
  logic clock = 1'b0;
  logic reset = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  pipe_reg_if #(.WIDTH(8),  .DEPTH(2)) bus_a ();
  pipe_reg_if #(.WIDTH(32), .DEPTH(1)) bus_b ();

  pipe_reg #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'h00)) dut_a (
    .clock(clock),
    .reset(reset),
    .bus  (bus_a)
  );

  pipe_reg #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'h0)) dut_b (
    .clock(clock),
    .reset(reset),
    .bus  (bus_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] sb [$];
  logic        rdy0;

  initial begin
    bus_a.flush = 1'b0; bus_a.in_valid = 1'b1; bus_a.in_data = 8'hFF; bus_a.out_ready = 1'b0;
    bus_b.flush = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_data = '0;    bus_b.out_ready = 1'b0;

    // Reset held with a word offered
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready",  32'(bus_a.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_out_data",  32'(bus_a.out_data),  32'h00);
    check("rst_count",     32'(bus_a.count),     32'd0);
    bus_a.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    check("rel_count",     32'(bus_a.count),     32'd0);
    check("rel_out_valid", 32'(bus_a.out_valid), 32'd0);

    // Streaming 0x01..0x10 with out_ready high
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      bus_a.in_valid = (i < 16);
      bus_a.in_data  = 8'(i + 1);
      #1;
      if (i < 16) check("stream_in_ready", 32'(bus_a.in_ready), 32'd1);
      check("stream_out_valid", 32'(bus_a.out_valid), 32'(i >= 2 && i <= 17));
      if (i >= 2 && i <= 17) check("stream_out_data", 32'(bus_a.out_data), 32'(i - 1));
      check("stream_count", 32'(bus_a.count),
            32'((i == 0) ? 0 : (i == 1) ? 1 : (i <= 16) ? 2 : (i == 17) ? 1 : 0));
      tick();
    end

    // Backpressure: exactly four words accepted, head word held
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus_a.in_data = 8'hA0 + 8'((i < 4) ? i : 4);
      #1;
      check("bp_in_ready",  32'(bus_a.in_ready),  32'(i < 4));
      check("bp_count",     32'(bus_a.count),     32'((i < 4) ? i : 4));
      check("bp_out_valid", 32'(bus_a.out_valid), 32'(i >= 2));
      if (i >= 2) check("bp_out_data", 32'(bus_a.out_data), 32'hA0);
      tick();
    end
    bus_a.out_ready = 1'b1;
    for (int j = 0; j < 11; j++) begin
      bus_a.in_valid = (j < 8);
      bus_a.in_data  = 8'hA4 + 8'((j < 2) ? 0 : j - 2);
      #1;
      if (j < 8) check("drain_in_ready", 32'(bus_a.in_ready), 32'(j >= 2));
      check("drain_out_valid", 32'(bus_a.out_valid), 32'(j < 10));
      if (j < 10) check("drain_out_data", 32'(bus_a.out_data), 32'hA0 + 32'(j));
      check("drain_count", 32'(bus_a.count),
            32'((j == 0) ? 4 : (j == 1) ? 3 : (j <= 8) ? 2 : (j == 9) ? 1 : 0));
      tick();
    end

    // Flush with three words stored and a word offered
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_a.in_data = 8'h31 + 8'(i);
      tick();
    end
    bus_a.flush   = 1'b1;
    bus_a.in_data = 8'h77;
    #1;
    check("fl_count_pre", 32'(bus_a.count),     32'd3);
    check("fl_in_ready",  32'(bus_a.in_ready),  32'd0);
    check("fl_out_valid", 32'(bus_a.out_valid), 32'd0);
    tick();
    check("fl_count_post", 32'(bus_a.count), 32'd0);
    tick();
    check("fl_hold_count", 32'(bus_a.count), 32'd0);
    bus_a.flush     = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    #1;
    check("fl_out_valid_post", 32'(bus_a.out_valid), 32'd0);
    check("fl_in_ready_post",  32'(bus_a.in_ready),  32'd1);
    for (int k = 0; k < 4; k++) begin
      bus_a.in_valid = (k == 0);
      bus_a.in_data  = 8'h55;
      #1;
      check("fl_push_out_valid", 32'(bus_a.out_valid), 32'(k == 2));
      if (k == 2) check("fl_push_out_data", 32'(bus_a.out_data), 32'h55);
      tick();
    end
    check("fl_final_count", 32'(bus_a.count), 32'd0);

    // Asynchronous reset between edges
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_a.in_data = 8'h41 + 8'(i);
      tick();
    end
    bus_a.in_valid = 1'b0;
    #1;
    check("ar_count_pre", 32'(bus_a.count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("ar_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("ar_count",     32'(bus_a.count),     32'd0);
    check("ar_out_data",  32'(bus_a.out_data),  32'h00);
    check("ar_in_ready",  32'(bus_a.in_ready),  32'd0);
    #2;
    reset = 1'b1;
    tick();
    check("ar_out_valid_post", 32'(bus_a.out_valid), 32'd0);

    // Random stalls on DEPTH=1 against a scoreboard
    for (int c = 0; c < 1000; c++) begin
      bus_b.in_valid  = 1'($urandom_range(0, 1));
      bus_b.in_data   = $urandom();
      bus_b.out_ready = 1'($urandom_range(0, 1));
      #1;
      rdy0 = bus_b.in_ready;
      bus_b.out_ready = ~bus_b.out_ready;
      #1;
      check("rnd_ready_indep", 32'(bus_b.in_ready), 32'(rdy0));
      bus_b.out_ready = ~bus_b.out_ready;
      #1;
      check("rnd_count",     32'(bus_b.count),     32'(sb.size()));
      check("rnd_out_valid", 32'(bus_b.out_valid), 32'(sb.size() != 0));
      if (sb.size() == 0) check("rnd_ready_empty", 32'(bus_b.in_ready), 32'd1);
      if (sb.size() == 2) check("rnd_ready_full",  32'(bus_b.in_ready), 32'd0);
      if (bus_b.out_valid && bus_b.out_ready && sb.size() != 0) begin
        check("rnd_out_data", bus_b.out_data, sb[0]);
        void'(sb.pop_front());
      end
      if (bus_b.in_valid && bus_b.in_ready) sb.push_back(bus_b.in_data);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
